// File: rtl/rv32i_fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request/response, redirect, and the
// instruction stream handed to decode.
interface rv32i_fetch_unit_if #(
  parameter int XLEN = 32
);
  // Every *_valid/*_ready pair transfers on a rising edge where both are high.
  // A source holds its payload stable while valid is high and ready is low.
  // imem_rsp and redirect have no ready: the fetch unit always takes them.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: sequential PC generation, credit-limited memory
// requests, in-order instruction buffer, redirect flush with stale-drop count.
module rv32i_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_fetch_unit_if.master bus
);
  localparam int              PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int              CNT_W     = $clog2(BUF_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [CNT_W:0]  DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [31:0]      instr_mem [BUF_DEPTH];
  logic [XLEN-1:0]  pc_mem    [BUF_DEPTH];

  logic [CNT_W:0]   occupancy;
  logic [XLEN-1:0]  redirect_target;
  logic             req_fire;
  logic             rsp_counted;
  logic             rsp_drop;
  logic             push;
  logic             pop;
  logic             unused_pc_lsbs;

  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs  = ^bus.redirect_pc[1:0];

  // The slot freed by this cycle's pop is reusable now, which keeps one
  // instruction per cycle flowing with only two buffer entries.
  assign pop       = bus.if_valid && bus.if_ready && !bus.redirect_valid;
  assign occupancy = {1'b0, count} - {{CNT_W{1'b0}}, pop} + {1'b0, outstanding};

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (occupancy < DEPTH_LIM);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_counted = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_drop    = bus.redirect_valid || (drop_cnt != '0);
  assign push        = bus.imem_rsp_valid && !rst && !rsp_drop;

  assign bus.if_valid = !rst && (count != '0);
  assign bus.if_instr = bus.if_valid ? instr_mem[head] : 32'h0;
  assign bus.if_pc    = bus.if_valid ? pc_mem[head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      case ({req_fire, rsp_counted})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase

      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the old path; the response
        // landing this cycle is already being discarded, so it is not counted.
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        drop_cnt <= outstanding - CNT_W'(rsp_counted);
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (bus.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_ONE;
        if (push) begin
          tail   <= tail + PTR_ONE;
          rsp_pc <= rsp_pc + PC_STEP;
        end
        if (pop) head <= head + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Responses return in request order, so the tag is the running rsp_pc.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= bus.imem_rsp_data;
      pc_mem[tail]    <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: in-order memory model plus a
// scoreboard of expected fetch addresses and delivered PCs.
module tb_rv32i_fetch_unit;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   mem_hold     = 1'b0;

  logic [31:0] exp_q  [$];
  logic [31:0] pend_q [$];
  logic [31:0] exp_addr = RESET_PC;

  rv32i_fetch_unit_if #(.XLEN(XLEN)) bus ();

  rv32i_fetch_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  // ---------------- memory model: in order, one cycle after acceptance
  always @(negedge clk) begin
    if (!rst && bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1)
      pend_q.push_back(bus.imem_req_addr);
  end

  always @(posedge clk) begin
    #2;
    if (rst) begin
      pend_q.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end else if (!mem_hold && pend_q.size() != 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(pend_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  end

  // ---------------- scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      tests_run++;
      if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0 ||
          bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0) begin
        tests_failed++;
        $display("FAIL sb_rst_outputs: got req_valid=%b if_valid=%b instr=%h pc=%h, expected all 0",
                 bus.imem_req_valid, bus.if_valid, bus.if_instr, bus.if_pc);
      end
      exp_q.delete();
      exp_addr = RESET_PC;
    end else if (bus.redirect_valid === 1'b1) begin
      tests_run++;
      if (bus.imem_req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL sb_redirect_req: got req_valid=%b, expected 0", bus.imem_req_valid);
      end
      exp_q.delete();
      exp_addr = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
        tests_run++;
        if (bus.imem_req_addr !== exp_addr) begin
          tests_failed++;
          $display("FAIL sb_req_addr: got %h, expected %h", bus.imem_req_addr, exp_addr);
        end
        exp_q.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got pc=%h, expected no instruction", bus.if_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.if_pc !== e || bus.if_instr !== instr_of(e)) begin
            tests_failed++;
            $display("FAIL sb_deliver: got pc=%h instr=%h, expected pc=%h instr=%h",
                     bus.if_pc, bus.if_instr, e, instr_of(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b0;
    bus.imem_req_ready = 1'b1;
    mem_hold           = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.if_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    tests_run++;
    if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: got req_valid=%b if_valid=%b, expected 0 0", bus.imem_req_valid, bus.if_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_first_req: got valid=%b addr=%h, expected 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_throughput();
    do_reset(3);
    bus.if_ready = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        tests_run++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC + 32'(4 * cyc)) begin
          tests_failed++;
          $display("FAIL thru_addr[%0d]: got valid=%b addr=%h, expected 1 %h",
                   cyc, bus.imem_req_valid, bus.imem_req_addr, RESET_PC + 32'(4 * cyc));
        end
      end
      if (cyc >= 2) begin
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== RESET_PC + 32'(4 * (cyc - 2))) begin
          tests_failed++;
          $display("FAIL thru_deliver[%0d]: got valid=%b pc=%h, expected 1 %h",
                   cyc, bus.if_valid, bus.if_pc, RESET_PC + 32'(4 * (cyc - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    do_reset(2);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) fires++;
      if (cyc >= 2) begin
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 ||
            bus.if_pc !== RESET_PC || bus.if_instr !== instr_of(RESET_PC)) begin
          tests_failed++;
          $display("FAIL bp_stable[%0d]: got if_valid=%b req_valid=%b pc=%h instr=%h, expected 1 0 %h %h",
                   cyc, bus.if_valid, bus.imem_req_valid, bus.if_pc, bus.if_instr,
                   RESET_PC, instr_of(RESET_PC));
        end
      end
    end
    tests_run++;
    if (fires != 2) begin
      tests_failed++;
      $display("FAIL bp_fires: got %0d requests, expected 2", fires);
    end
    @(posedge clk); #1;
    bus.if_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== RESET_PC + 32'(4 * k)) begin
        tests_failed++;
        $display("FAIL bp_order[%0d]: got valid=%b pc=%h, expected 1 %h",
                 k, bus.if_valid, bus.if_pc, RESET_PC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset(2);
    bus.if_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_if_valid: got %b, expected 0", bus.if_valid);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
        found = 1'b1;
        tests_run++;
        if (bus.imem_req_addr !== 32'h0000_0100) begin
          tests_failed++;
          $display("FAIL redir_addr: got %h, expected 00000100", bus.imem_req_addr);
        end
      end else @(negedge clk);
    end
    if (!found) begin
      tests_run++; tests_failed++;
      $display("FAIL redir_addr_timeout: got no request, expected addr 00000100");
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.if_valid === 1'b1) begin
        found = 1'b1;
        tests_run++;
        if (bus.if_pc !== 32'h0000_0100) begin
          tests_failed++;
          $display("FAIL redir_first_pc: got %h, expected 00000100", bus.if_pc);
        end
      end else @(negedge clk);
    end
    if (!found) begin
      tests_run++; tests_failed++;
      $display("FAIL redir_pc_timeout: got no instruction, expected pc 00000100");
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    do_reset(2);
    bus.if_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    mem_hold = 1'b0;
    @(posedge clk); #1;
    bus.redirect_pc    = 32'h0000_030D;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.if_valid === 1'b1) begin
        found = 1'b1;
        tests_run++;
        if (bus.if_pc !== 32'h0000_030C || bus.if_instr !== instr_of(32'h0000_030C)) begin
          tests_failed++;
          $display("FAIL b2b_first: got pc=%h instr=%h, expected pc=0000030c instr=%h",
                   bus.if_pc, bus.if_instr, instr_of(32'h0000_030C));
        end
      end
    end
    if (!found) begin
      tests_run++; tests_failed++;
      $display("FAIL b2b_timeout: got no instruction, expected pc 0000030c");
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [31:0] want [2];
    want[0] = 32'hFFFF_FFFC;
    want[1] = 32'h0000_0000;
    do_reset(2);
    bus.if_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      @(negedge clk);
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
        tests_run++;
        if (bus.imem_req_addr !== want[n]) begin
          tests_failed++;
          $display("FAIL wrap_addr[%0d]: got %h, expected %h", n, bus.imem_req_addr, want[n]);
        end
        n++;
      end
    end
    if (n < 2) begin
      tests_run++; tests_failed++;
      $display("FAIL wrap_timeout: got %0d requests, expected 2", n);
    end
  endtask

  task automatic test_ready_toggle();
    logic [31:0] prev_addr = RESET_PC - 32'd4;
    logic [31:0] prev_pc   = RESET_PC - 32'd4;
    int delivered = 0;
    do_reset(2);
    bus.if_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.imem_req_ready = cyc[0];
      @(negedge clk);
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
        tests_run++;
        if (bus.imem_req_addr !== prev_addr + 32'd4) begin
          tests_failed++;
          $display("FAIL toggle_addr: got %h, expected %h", bus.imem_req_addr, prev_addr + 32'd4);
        end
        prev_addr = prev_addr + 32'd4;
      end
      if (bus.if_valid === 1'b1) begin
        tests_run++;
        if (bus.if_pc !== prev_pc + 32'd4) begin
          tests_failed++;
          $display("FAIL toggle_pc: got %h, expected %h", bus.if_pc, prev_pc + 32'd4);
        end
        prev_pc = prev_pc + 32'd4;
        delivered++;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (delivered < 10) begin
      tests_failed++;
      $display("FAIL toggle_count: got %0d deliveries, expected at least 10", delivered);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset(2);
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.if_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_full: got if_valid=%b, expected 1", bus.if_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (bus.if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_flush: got if_valid=%b, expected 0", bus.if_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.if_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL rmid_first_req: got valid=%b addr=%h, expected 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.if_valid === 1'b1) begin
        found = 1'b1;
        tests_run++;
        if (bus.if_pc !== RESET_PC) begin
          tests_failed++;
          $display("FAIL rmid_first_pc: got %h, expected %h", bus.if_pc, RESET_PC);
        end
      end else @(negedge clk);
    end
    if (!found) begin
      tests_run++; tests_failed++;
      $display("FAIL rmid_timeout: got no instruction, expected pc %h", RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          held = 1'b0;
    logic [31:0] held_pc = '0;
    logic [31:0] held_instr = '0;
    do_reset(2);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      mem_hold           = ($urandom_range(0, 4) == 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc    = $urandom;
      @(negedge clk);
      if (held) begin
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== held_pc || bus.if_instr !== held_instr) begin
          tests_failed++;
          $display("FAIL rand_stable: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                   bus.if_valid, bus.if_pc, bus.if_instr, held_pc, held_instr);
        end
      end
      held       = (bus.if_valid === 1'b1) && (bus.if_ready === 1'b0) && (bus.redirect_valid === 1'b0);
      held_pc    = bus.if_pc;
      held_instr = bus.if_instr;
      @(posedge clk); #1;
    end
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b1;
    bus.imem_req_ready = 1'b1;
    mem_hold           = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    test_reset();
    test_throughput();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_ready_toggle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule

// File: doc/rv32i_fetch_unit.md
RV32I_FETCH_UNIT -- requirements
Module: rv32i_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address/PC width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 2: instruction buffer entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 imem_req_valid  output  1  fetch request offered to instruction memory.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  read data returned; in order, earliest one cycle after acceptance.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-012 redirect_pc  input  XLEN  redirect target.
REQ-013 if_valid  output  1  instruction available to decode/register-file stage.
REQ-014 if_ready  input  1  downstream consumes instruction.
REQ-015 if_instr  output  32  head instruction.
REQ-016 if_pc  output  XLEN  PC of head instruction.

Function
REQ-017 Request handshake SHALL complete when imem_req_valid and imem_req_ready are both high on a rising edge.
REQ-018 imem_req_addr SHALL equal fetch PC; fetch PC SHALL advance by 4 on each handshake, wrapping modulo 2^XLEN.
REQ-019 imem_req_valid SHALL be high only when (buffered entries + outstanding requests) < BUF_DEPTH, redirect_valid is low, and rst is low.
REQ-020 Outstanding counter SHALL increment on request handshake, decrement on imem_rsp_valid, both in same cycle leave it unchanged.
REQ-021 Each accepted response (not dropped) SHALL be written to buffer tail with its PC; PC tags SHALL be kept in a parallel in-order queue.
REQ-022 Buffer SHALL be FIFO; if_valid high when non-empty; if_instr/if_pc from head.
REQ-023 Pop SHALL occur when if_valid and if_ready are high; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-024 While if_valid high and if_ready low, if_instr and if_pc SHALL stay stable unless a redirect occurs.
REQ-025 Buffer never overflows: a response SHALL never arrive without a reserved slot, guaranteed by REQ-019.
REQ-026 On redirect_valid: buffer flushed, fetch PC <= {redirect_pc[XLEN-1:2], 2'b00}, drop counter <= outstanding count minus any response arriving that cycle.
REQ-027 Responses arriving while drop counter > 0 SHALL be discarded and decrement drop counter; response in the redirect cycle itself SHALL be discarded.
REQ-028 if_valid SHALL be low in the cycle after redirect; pop in redirect cycle SHALL be ignored.
REQ-029 First post-redirect request SHALL be offered in the cycle after redirect_valid, subject to REQ-019 (dropped outstanding requests still count as outstanding).
REQ-030 Back-to-back redirects: latest target wins; drop counter accumulates correctly.
REQ-031 Full throughput: with memory ready every cycle and 1-cycle response, one instruction per cycle SHALL be delivered when if_ready is held high.

Reset
REQ-032 While rst high: imem_req_valid 0, if_valid 0, fetch PC = RESET_PC, buffer empty, outstanding and drop counters 0, if_instr 0, if_pc 0.
REQ-033 Reset mid-operation SHALL discard buffered and in-flight instructions; responses arriving during rst ignored; responses after rst to pre-reset requests are out of scope (memory also reset).
REQ-034 First request (addr RESET_PC) SHALL be offered in the first cycle rst is low.

Verification
REQ-035 Reset release, memory always ready, 1-cycle response, if_ready=1 -> addrs 0x0,0x4,0x8 on consecutive cycles; if_pc 0x0,0x4,0x8 one per cycle.
REQ-036 if_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_valid low, if_instr/if_pc stable; on if_ready=1 order 0x0 then 0x4.
REQ-037 Redirect to 0x103 with 2 requests outstanding -> next addr 0x100, two stale responses dropped, first if_pc 0x100.
REQ-038 imem_req_ready toggling 1/0 -> no address skipped or duplicated; if_pc strictly +4 sequence.
REQ-039 Fetch PC 0xFFFF_FFFC (via redirect) -> next addr 0x0000_0000.
REQ-040 rst asserted with full buffer -> next cycle if_valid 0; after release first addr RESET_PC.
